palette_arbiter: RTL and testbench
==================================

# palette_arbiter

Sequencer and arbiter for the 256×16 palette RAM (`ram_color`). Shares the RAM between three users:
- the video pixel path, which reads one entry per active pixel and always has read-port priority;
- the CPU bus, which does single-entry reads and byte-masked writes under a req/ack handshake;
- a fill engine, which writes one constant to a range of entries.

Sits between the pixel pipeline and `ram_color`, and drives all of the RAM's ports.

## Interface
- `AW`, 8, palette index width; RAM address ports are zero-extended to 16 bits.
- `DW`, 16, palette entry width.

- `clk`  in  1  single clock, shared with `ram_color`.
- `rst`  in  1  synchronous reset, active-high.
- `pix_valid`  in  1  video lookup request this cycle.
- `pix_index`  in  AW  palette index for the video lookup.
- `rgb_valid`  out  1  `rgb_data` is valid this cycle.
- `rgb_data`  out  DW  palette entry for the video lookup.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_be`  in  2  active-high byte enables; [1] = bits 15:8, [0] = bits 7:0.
- `cpu_addr`  in  AW  CPU palette index.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data; valid when `cpu_ack` follows a read, otherwise holds its last value.
- `fill_start`  in  1  start-fill pulse.
- `fill_first`, `fill_last`  in  AW  inclusive fill range.
- `fill_data`  in  DW  fill value.
- `fill_busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse on fill completion.
- `ram_we_n`, `ram_he_n`, `ram_le_n`  out  1  active-low write strobe and byte enables to the RAM.
- `ram_addr_w`, `ram_addr_r`  out  16  RAM write and read addresses.
- `ram_data_w`  out  DW  RAM write data.
- `ram_data_r`  in  DW  RAM read data; one cycle of RAM latency.

## Operation
- **FSM states:** IDLE, WR_ACK, RD_ISSUED, RD_ACK, FILL. Grants are made only in IDLE.
- **Priority in IDLE:** `fill_start` first, then `cpu_req`. `fill_start` in any state other than IDLE is ignored.
- **Video path:**
  - Independent of the FSM and never stalls.
  - `ram_addr_r` = `pix_index` whenever `pix_valid`=1.
  - A 2-stage valid shift produces `rgb_valid`/`rgb_data`.
- **CPU write:**
  - Grant requires IDLE with `cpu_we`=1.
  - In the grant cycle, the RAM write strobe is driven combinationally: `ram_we_n`=0, `ram_he_n`=~`cpu_be`[1], `ram_le_n`=~`cpu_be`[0], address and data from the CPU.
  - Next state is WR_ACK, in which `cpu_ack`=1, then back to IDLE.
  - `cpu_be`=00 still completes and acks, but leaves the RAM unchanged.
- **CPU read:**
  - Grant requires IDLE with `cpu_we`=0 and `pix_valid`=0.
  - In the grant cycle, `ram_addr_r` = `cpu_addr`.
  - Sequence is RD_ISSUED, then RD_ACK. In RD_ACK, `cpu_rdata` is loaded and `cpu_ack`=1.
  - A read is deferred indefinitely while `pix_valid`=1. Blanking guarantees progress.
- **Fill:**
  - `fill_first`, `fill_last` and `fill_data` are latched at start.
  - One full-word write per cycle (`ram_he_n`=`ram_le_n`=0), starting at `first`.
  - The address increments modulo 256, so `last < first` wraps through 255→0. `first == last` writes exactly one entry.
  - The write to `last` is the final write. `fill_done` pulses the next cycle, in IDLE.
  - CPU requests stall for the whole fill.
- **Hazard:** the RAM is read-first. A video read of an address written in the same cycle returns the old value. This is accepted behaviour.
- **Requester rule:** `cpu_req` is ignored in the ack cycle. The requester drops `cpu_req`, or presents its next request, from the cycle after `cpu_ack`.
- **Reset:** takes effect at any time and aborts a fill or pending CPU access. No ack or done is issued. The FSM returns to IDLE.
- **Reset values:**
  - `rgb_valid`, `cpu_ack`, `fill_busy`, `fill_done` = 0.
  - `rgb_data`, `cpu_rdata` = 0.
  - `ram_we_n`, `ram_he_n`, `ram_le_n` = 1.
  - Addresses and `ram_data_w` = 0.

## Timing
- **Video:** `pix_valid` in cycle N gives `rgb_valid`=1 with data in N+2. Throughput is one lookup per cycle.
- **CPU write:** grant in G, RAM written at the end of G, `cpu_ack` in G+1. Next grant no earlier than G+2.
- **CPU read:** grant in G, `cpu_ack` and `cpu_rdata` in G+2. A write completed in G−1 or earlier is visible.
- **Fill:** `fill_start` in S gives `fill_busy`=1 from S+1. Writes occur in S+1 … S+n, where n = (`last`−`first`) mod 256 + 1. `fill_busy`=0 and `fill_done`=1 in S+n+1.
- **Write-port inactive cycles:** `ram_we_n`=`ram_he_n`=`ram_le_n`=1 in every cycle without a granted write.

## Structure
- **Package `palette_pkg`:** FSM state enum, `PAL_AW`=8, `PAL_DW`=16, `PAL_RD_LAT`=2.
- **Sub-module `pal_fill_seq`:** fill address counter with wrap and last-detect; provides `busy` and `done`.

## Test plan
- **Video latency and throughput:** `pix_valid` for 4 cycles with indices 0x10…0x13, RAM preloaded with entry = index×0x0101 → `rgb_valid` in cycles 3…6 with data 0x1010, 0x1111, 0x1212, 0x1313.
- **Byte-masked write:** CPU write addr 0x05, `be`=10, data 0xABCD onto 0x1234 → ack in G+1; CPU read addr 0x05 → `cpu_rdata`=0xAB34.
- **Read deferral:** CPU read asserted during 20 cycles of `pix_valid`=1 → no ack; ack 2 cycles after `pix_valid` drops; video data uncorrupted.
- **Wrap-around fill:** `first`=0xFE, `last`=0x01, data 0x7C00 → 4 writes to 0xFE, 0xFF, 0x00, 0x01; `fill_done` at S+5; entry 0x02 unchanged.
- **Fill/CPU collision:** `fill_start` and CPU write in the same IDLE cycle → fill runs first; CPU ack arrives 1 cycle after `fill_done`'s IDLE grant.
- **Reset mid-fill:** `rst` at the 3rd fill write → no `fill_done`; all outputs at reset values; entries beyond the 3rd written entry unchanged.

Source files
------------

// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared types and sizes for the palette RAM arbiter
package palette_pkg;
  localparam int PAL_AW     = 8;
  localparam int PAL_DW     = 16;
  localparam int PAL_RD_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACK,
    ST_RD_ISSUED,
    ST_RD_ACK,
    ST_FILL
  } pal_state_e;
endpackage

// File: rtl/pal_fill_seq.sv
// rtl/pal_fill_seq.sv - fill address walker: wraps modulo 2^AW, flags the last entry
module pal_fill_seq
  import palette_pkg::*;
#(
  parameter int AW = PAL_AW,
  parameter int DW = PAL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] first_i,
  input  logic [AW-1:0] last_i,
  input  logic [DW-1:0] data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          at_last_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          at_last;

  assign at_last = busy_q && (addr_q == last_q);

  always_comb begin
    addr_d = addr_q;
    last_d = last_q;
    data_d = data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      addr_d = first_i;
      last_d = last_i;
      data_d = data_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // first == last falls straight into this branch: exactly one write
      if (at_last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      last_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      last_q <= last_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign at_last_o = at_last;
  assign addr_o    = addr_q;
  assign data_o    = data_q;

endmodule

// File: rtl/palette_arbiter.sv
// rtl/palette_arbiter.sv - shares the palette RAM between video reads, CPU access and fill
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int AW = PAL_AW,
  parameter int DW = PAL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [AW-1:0] pix_index,
  output logic          rgb_valid,
  output logic [DW-1:0] rgb_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_first,
  input  logic [AW-1:0] fill_last,
  input  logic [DW-1:0] fill_data,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          ram_we_n,
  output logic          ram_he_n,
  output logic          ram_le_n,
  output logic [15:0]   ram_addr_w,
  output logic [15:0]   ram_addr_r,
  output logic [DW-1:0] ram_data_w,
  input  logic [DW-1:0] ram_data_r
);

  pal_state_e state_q, state_d;

  logic                  in_idle;
  logic                  fill_grant, wr_grant, rd_grant;
  logic                  seq_busy, seq_done, seq_at_last;
  logic [AW-1:0]         seq_addr;
  logic [DW-1:0]         seq_data;
  logic [PAL_RD_LAT-1:0] vld_q;
  logic [DW-1:0]         rgb_data_q;
  logic [DW-1:0]         cpu_rdata_q;

  assign in_idle    = (state_q == ST_IDLE);
  assign fill_grant = in_idle && fill_start;
  assign wr_grant   = in_idle && !fill_start && cpu_req && cpu_we;
  assign rd_grant   = in_idle && !fill_start && cpu_req && !cpu_we && !pix_valid;

  pal_fill_seq #(
    .AW(AW),
    .DW(DW)
  ) u_fill_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (fill_grant),
    .first_i  (fill_first),
    .last_i   (fill_last),
    .data_i   (fill_data),
    .busy_o   (seq_busy),
    .done_o   (seq_done),
    .at_last_o(seq_at_last),
    .addr_o   (seq_addr),
    .data_o   (seq_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_grant)    state_d = ST_FILL;
        else if (wr_grant) state_d = ST_WR_ACK;
        else if (rd_grant) state_d = ST_RD_ISSUED;
      end
      ST_WR_ACK:    state_d = ST_IDLE;
      ST_RD_ISSUED: state_d = ST_RD_ACK;
      ST_RD_ACK:    state_d = ST_IDLE;
      ST_FILL:      if (seq_at_last) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // RAM ports are combinational so a CPU write lands at the end of its grant cycle;
  // reset forces every strobe, address and pulse to its idle value immediately.
  always_comb begin
    ram_we_n   = 1'b1;
    ram_he_n   = 1'b1;
    ram_le_n   = 1'b1;
    ram_addr_w = '0;
    ram_data_w = '0;
    ram_addr_r = '0;
    cpu_ack    = 1'b0;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    if (!rst) begin
      if (pix_valid)     ram_addr_r = 16'(pix_index);
      else if (rd_grant) ram_addr_r = 16'(cpu_addr);
      if (wr_grant) begin
        ram_we_n   = 1'b0;
        ram_he_n   = ~cpu_be[1];
        ram_le_n   = ~cpu_be[0];
        ram_addr_w = 16'(cpu_addr);
        ram_data_w = cpu_wdata;
      end else if (state_q == ST_FILL) begin
        ram_we_n   = 1'b0;
        ram_he_n   = 1'b0;
        ram_le_n   = 1'b0;
        ram_addr_w = 16'(seq_addr);
        ram_data_w = seq_data;
      end
      cpu_ack   = (state_q == ST_WR_ACK) || (state_q == ST_RD_ACK);
      fill_busy = seq_busy;
      fill_done = seq_done;
    end
  end

  // Video path: one stage covers RAM latency, the second registers the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      rgb_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      vld_q <= {vld_q[PAL_RD_LAT-2:0], pix_valid};
      if (vld_q[PAL_RD_LAT-2]) rgb_data_q <= ram_data_r;
      if (state_q == ST_RD_ISSUED) cpu_rdata_q <= ram_data_r;
    end
  end

  assign rgb_valid = vld_q[PAL_RD_LAT-1];
  assign rgb_data  = rgb_data_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// tb/tb_palette_arbiter.sv - randomized self-checking bench for palette_arbiter
module tb_palette_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_index;
  logic        rgb_valid;
  logic [15:0] rgb_data;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        fill_start;
  logic [7:0]  fill_first, fill_last;
  logic [15:0] fill_data;
  logic        fill_busy, fill_done;
  logic        ram_we_n, ram_he_n, ram_le_n;
  logic [15:0] ram_addr_w, ram_addr_r, ram_data_w;
  logic [15:0] ram_data_r;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        load_req = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  palette_arbiter dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_index(pix_index),
    .rgb_valid(rgb_valid), .rgb_data(rgb_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_first(fill_first), .fill_last(fill_last),
    .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_we_n(ram_we_n), .ram_he_n(ram_he_n), .ram_le_n(ram_le_n),
    .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r), .ram_data_w(ram_data_w),
    .ram_data_r(ram_data_r)
  );

  // Read-first palette RAM with one cycle of read latency
  always @(posedge clk) begin
    if (load_req) begin
      mem <= ref_mem;
    end else if (!ram_we_n) begin
      if (!ram_he_n) mem[ram_addr_w[7:0]][15:8] <= ram_data_w[15:8];
      if (!ram_le_n) mem[ram_addr_w[7:0]][7:0]  <= ram_data_w[7:0];
    end
    ram_data_r <= mem[ram_addr_r[7:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 0; pix_index = 0; cpu_req = 0; cpu_we = 0; cpu_be = 0;
      cpu_addr = 0; cpu_wdata = 0; fill_start = 0; fill_first = 0; fill_last = 0; fill_data = 0;
    end
  endtask

  task automatic sync_ram();
    @(negedge clk); load_req = 1;
    @(negedge clk); load_req = 0;
  endtask

  // Presents one CPU request from the next cycle; returns at the ack cycle (req still high)
  task automatic cpu_xact(input logic we, input logic [1:0] be, input logic [7:0] addr,
                          input logic [15:0] wd, output int lat, output logic [15:0] rd);
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    lat = -1; rd = 'x;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (cpu_ack) begin lat = k; rd = cpu_rdata; break; end
    end
    if (we) begin
      if (be[1]) ref_mem[addr][15:8] = wd[15:8];
      if (be[0]) ref_mem[addr][7:0]  = wd[7:0];
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle(2);
    #1;
    checks += 12;
    if (rgb_valid !== 0)        begin errors++; $display("FAIL reset rgb_valid got %b exp 0", rgb_valid); end
    if (rgb_data !== 0)         begin errors++; $display("FAIL reset rgb_data got %h exp 0", rgb_data); end
    if (cpu_ack !== 0)          begin errors++; $display("FAIL reset cpu_ack got %b exp 0", cpu_ack); end
    if (cpu_rdata !== 0)        begin errors++; $display("FAIL reset cpu_rdata got %h exp 0", cpu_rdata); end
    if (fill_busy !== 0)        begin errors++; $display("FAIL reset fill_busy got %b exp 0", fill_busy); end
    if (fill_done !== 0)        begin errors++; $display("FAIL reset fill_done got %b exp 0", fill_done); end
    if (ram_we_n !== 1)         begin errors++; $display("FAIL reset ram_we_n got %b exp 1", ram_we_n); end
    if (ram_he_n !== 1)         begin errors++; $display("FAIL reset ram_he_n got %b exp 1", ram_he_n); end
    if (ram_le_n !== 1)         begin errors++; $display("FAIL reset ram_le_n got %b exp 1", ram_le_n); end
    if (ram_addr_w !== 0)       begin errors++; $display("FAIL reset ram_addr_w got %h exp 0", ram_addr_w); end
    if (ram_addr_r !== 0)       begin errors++; $display("FAIL reset ram_addr_r got %h exp 0", ram_addr_r); end
    if (ram_data_w !== 0)       begin errors++; $display("FAIL reset ram_data_w got %h exp 0", ram_data_w); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_video();
    logic       hv [64];
    logic [7:0] hi [64];
    idle(3);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (t < 4)       begin pix_valid = 1; pix_index = 8'h10 + 8'(t); end
      else if (t < 44) begin pix_valid = 1'($urandom); pix_index = 8'($urandom); end
      else             begin pix_valid = 0; pix_index = 0; end
      hv[t] = pix_valid; hi[t] = pix_index;
      #1;
      if (pix_valid) begin
        checks++;
        if (ram_addr_r !== {8'h00, pix_index}) begin errors++; $display("FAIL video ram_addr_r t=%0d got %h exp %h", t, ram_addr_r, pix_index); end
      end
      checks++;
      if (rgb_valid !== (t >= 2 ? hv[t-2] : 1'b0)) begin errors++; $display("FAIL video rgb_valid t=%0d got %b", t, rgb_valid); end
      if (t >= 2 && hv[t-2]) begin
        checks++;
        if (rgb_data !== ref_mem[hi[t-2]]) begin errors++; $display("FAIL video rgb_data t=%0d got %h exp %h", t, rgb_data, ref_mem[hi[t-2]]); end
      end
    end
  endtask

  task automatic test_byte_write();
    int lat; logic [15:0] rd;
    cpu_xact(1, 2'b11, 8'h05, 16'h1234, lat, rd);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bw_first_write latency got %0d exp 1", lat); end
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_be = 2'b10; cpu_addr = 8'h05; cpu_wdata = 16'hABCD;
    #1;
    checks++;
    if ({ram_we_n, ram_he_n, ram_le_n, ram_addr_w, ram_data_w, cpu_ack} !== {3'b001, 16'h0005, 16'hABCD, 1'b0}) begin
      errors++; $display("FAIL bw_grant strobes got we%b he%b le%b a%h d%h ack%b exp we0 he0 le1 a0005 dABCD ack0",
                         ram_we_n, ram_he_n, ram_le_n, ram_addr_w, ram_data_w, cpu_ack);
    end
    @(negedge clk); #1;
    checks++;
    if (cpu_ack !== 1 || ram_we_n !== 1) begin errors++; $display("FAIL bw_ack got ack%b we%b exp ack1 we1", cpu_ack, ram_we_n); end
    ref_mem[5][15:8] = 8'hAB;
    cpu_xact(0, 2'b00, 8'h05, 16'h0000, lat, rd);
    checks++;
    if (lat !== 2 || rd !== 16'hAB34) begin errors++; $display("FAIL bw_readback got lat%0d %h exp lat2 AB34", lat, rd); end
    cpu_xact(1, 2'b00, 8'h05, 16'hFFFF, lat, rd);
    cpu_xact(0, 2'b00, 8'h05, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'hAB34) begin errors++; $display("FAIL bw_be00_unchanged got %h exp AB34", rd); end
    idle(2);
  endtask

  task automatic test_random_cpu();
    int lat; logic [15:0] rd, exp_rd;
    logic we; logic [1:0] be; logic [7:0] a; logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); be = 2'($urandom); a = 8'($urandom_range(0, 15)); d = 16'($urandom);
      exp_rd = ref_mem[a];
      cpu_xact(we, be, a, d, lat, rd);
      checks++;
      if (lat !== (we ? 1 : 2)) begin errors++; $display("FAIL rand_cpu latency i=%0d we=%b got %0d", i, we, lat); end
      if (!we) begin
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL rand_cpu rdata i=%0d addr %h got %h exp %h", i, a, rd, exp_rd); end
      end
    end
    idle(3);
  endtask

  task automatic test_read_defer();
    logic       hv [32];
    logic [7:0] hi [32];
    logic [7:0] a;
    a = 8'($urandom_range(0, 15));
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      pix_valid = (t < 20); pix_index = (t < 20) ? 8'($urandom) : 8'h00;
      cpu_req = (t < 23); cpu_we = 0; cpu_addr = a;
      hv[t] = pix_valid; hi[t] = pix_index;
      #1;
      checks++;
      if (cpu_ack !== (t == 22)) begin errors++; $display("FAIL defer cpu_ack t=%0d got %b", t, cpu_ack); end
      if (t == 22) begin
        checks++;
        if (cpu_rdata !== ref_mem[a]) begin errors++; $display("FAIL defer cpu_rdata got %h exp %h", cpu_rdata, ref_mem[a]); end
      end
      if (t == 20) begin
        checks++;
        if (ram_addr_r !== {8'h00, a}) begin errors++; $display("FAIL defer grant addr got %h exp %h", ram_addr_r, a); end
      end
      if (t >= 2 && hv[t-2]) begin
        checks++;
        if (rgb_valid !== 1 || rgb_data !== ref_mem[hi[t-2]]) begin
          errors++; $display("FAIL defer video t=%0d got v%b %h exp %h", t, rgb_valid, rgb_data, ref_mem[hi[t-2]]);
        end
      end
    end
    idle(2);
  endtask

  // Runs one fill and checks every cycle from start until one cycle past done
  task automatic run_fill(input logic [7:0] f, input logic [7:0] l, input logic [15:0] d, input string tag);
    int n;
    logic [7:0] ea;
    n = int'(8'(l - f)) + 1;
    for (int t = 0; t <= n + 2; t++) begin
      @(negedge clk);
      fill_start = (t == 0);
      fill_first = (t == 0) ? f : 8'($urandom);
      fill_last  = (t == 0) ? l : 8'($urandom);
      fill_data  = (t == 0) ? d : 16'($urandom);
      #1;
      checks++;
      if (fill_busy !== (t >= 1 && t <= n) || fill_done !== (t == n + 1)) begin
        errors++; $display("FAIL %s busy/done t=%0d got %b%b", tag, t, fill_busy, fill_done);
      end
      if (t >= 1 && t <= n) begin
        ea = f + 8'(t - 1);
        checks++;
        if ({ram_we_n, ram_he_n, ram_le_n, ram_addr_w, ram_data_w} !== {3'b000, 8'h00, ea, d}) begin
          errors++; $display("FAIL %s write t=%0d got we%b%b%b a%h d%h exp a%h d%h", tag, t,
                             ram_we_n, ram_he_n, ram_le_n, ram_addr_w, ram_data_w, ea, d);
        end
      end else begin
        checks++;
        if (ram_we_n !== 1) begin errors++; $display("FAIL %s idle write port t=%0d got we%b exp 1", tag, t, ram_we_n); end
      end
    end
    for (int k = 0; k < n; k++) ref_mem[8'(f + 8'(k))] = d;
    idle(2);
  endtask

  task automatic test_fill_wrap();
    for (int i = 8'hFC; i < 8'hFC + 8; i++) ref_mem[8'(i)] = 16'($urandom);
    sync_ram();
    run_fill(8'hFE, 8'h01, 16'h7C00, "fill_wrap");
    for (int i = 8'hFC; i < 8'hFC + 8; i++) begin
      checks++;
      if (mem[8'(i)] !== ref_mem[8'(i)]) begin errors++; $display("FAIL fill_wrap entry %h got %h exp %h", 8'(i), mem[8'(i)], ref_mem[8'(i)]); end
    end
    checks++;
    if (mem[8'h00] !== 16'h7C00) begin errors++; $display("FAIL fill_wrap entry 00 got %h exp 7C00", mem[8'h00]); end
  endtask

  task automatic test_fill_random();
    int bad;
    for (int r = 0; r < 3; r++) begin
      run_fill(8'($urandom), 8'($urandom), 16'($urandom), "fill_rand");
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL fill_rand contents got %0d wrong entries exp 0", bad); end
    end
    run_fill(8'h77, 8'h77, 16'h5A5A, "fill_single");
  endtask

  task automatic test_collision();
    logic [15:0] fd, cd;
    fd = 16'($urandom); cd = 16'($urandom);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      fill_start = (t == 0); fill_first = 8'h20; fill_last = 8'h22; fill_data = fd;
      cpu_req = (t < 6); cpu_we = 1; cpu_be = 2'b11; cpu_addr = 8'h30; cpu_wdata = cd;
      #1;
      checks++;
      if (cpu_ack !== (t == 5) || fill_done !== (t == 4)) begin errors++; $display("FAIL collide ack/done t=%0d got %b%b", t, cpu_ack, fill_done); end
      checks++;
      case (t)
        1, 2, 3: if (ram_we_n !== 0 || ram_addr_w !== 16'h0020 + 16'(t - 1) || ram_data_w !== fd) begin
                   errors++; $display("FAIL collide fill write t=%0d got we%b a%h d%h", t, ram_we_n, ram_addr_w, ram_data_w);
                 end
        4:       if (ram_we_n !== 0 || ram_addr_w !== 16'h0030 || ram_data_w !== cd) begin
                   errors++; $display("FAIL collide cpu grant got we%b a%h d%h exp a0030 d%h", ram_we_n, ram_addr_w, ram_data_w, cd);
                 end
        default: if (ram_we_n !== 1) begin errors++; $display("FAIL collide idle port t=%0d got we%b exp 1", t, ram_we_n); end
      endcase
    end
    for (int k = 8'h20; k <= 8'h22; k++) ref_mem[k] = fd;
    ref_mem[8'h30] = cd;
    idle(2);
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] d;
    int bad;
    d = 16'($urandom);
    for (int i = 8'h40; i <= 8'h4F; i++) ref_mem[i] = ~d;
    sync_ram();
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      fill_start = (t == 0); fill_first = 8'h40; fill_last = 8'h4F; fill_data = d;
      rst = (t == 3 || t == 4);
      #1;
      if (t >= 3) begin
        checks++;
        if (fill_done !== 0 || fill_busy !== 0 || ram_we_n !== 1 || cpu_ack !== 0) begin
          errors++; $display("FAIL rst_fill outputs t=%0d got done%b busy%b we%b ack%b exp 0010", t, fill_done, fill_busy, ram_we_n, cpu_ack);
        end
      end
      if (t == 4) begin
        checks++;
        if ({rgb_valid, rgb_data, cpu_rdata, ram_he_n, ram_le_n, ram_addr_w, ram_addr_r, ram_data_w} !==
            {1'b0, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0, 16'h0}) begin
          errors++; $display("FAIL rst_fill reset values got v%b rgb%h rd%h he%b le%b aw%h ar%h dw%h",
                             rgb_valid, rgb_data, cpu_rdata, ram_he_n, ram_le_n, ram_addr_w, ram_addr_r, ram_data_w);
        end
      end
    end
    checks++;
    if (mem[8'h40] !== d || mem[8'h41] !== d) begin errors++; $display("FAIL rst_fill early entries got %h %h exp %h", mem[8'h40], mem[8'h41], d); end
    bad = 0;
    for (int i = 8'h43; i <= 8'h4F; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_fill untouched entries got %0d changed exp 0", bad); end
    ref_mem[8'h40] = d; ref_mem[8'h41] = d;
    sync_ram();
  endtask

  task automatic test_final_contents();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL final contents got %0d wrong entries exp 0", bad); end
  endtask

  initial begin
    rst = 1; pix_valid = 0; pix_index = 0; cpu_req = 0; cpu_we = 0; cpu_be = 0;
    cpu_addr = 0; cpu_wdata = 0; fill_start = 0; fill_first = 0; fill_last = 0; fill_data = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i) * 16'h0101;
    test_reset();
    sync_ram();
    test_video();
    test_byte_write();
    test_random_cpu();
    test_read_defer();
    test_fill_wrap();
    test_fill_random();
    test_collision();
    test_reset_mid_fill();
    test_final_contents();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
